dot_seq_ctrl: RTL and testbench
===============================

DOT_SEQ_CTRL -- requirements
Module: dot_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, vector length (lanes).
REQ-002 SHALL have parameter DW, default 8, element and byte width.
REQ-003 SHALL have parameter RW, default 24, dot-product result width; always 3 bytes.
REQ-004 SHALL have parameter DP_LAT, default 4, datapath cycles from dp_start to a valid dp_result.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid  input  1  host byte valid.
REQ-008 SHALL have port in_ready  output  1  controller accepts host byte.
REQ-009 SHALL have port in_data  input  DW  host command or operand byte.
REQ-010 SHALL have port mem_we  output  1  datapath operand-store write strobe.
REQ-011 SHALL have port mem_addr  output  6  operand address: 0..15 = A, 16..31 = B.
REQ-012 SHALL have port mem_wdata  output  DW  operand write data.
REQ-013 SHALL have port dp_start  output  1  one-cycle compute trigger to the multiplier/adder tree.
REQ-014 SHALL have port dp_result  input  RW  dot-product sum from the datapath.
REQ-015 SHALL have port out_valid  output  1  result byte valid.
REQ-016 SHALL have port out_ready  input  1  sink accepts result byte.
REQ-017 SHALL have port out_data  output  DW  result byte.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port err  output  1  sticky: unknown command seen.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, WAIT, OUT; a transfer occurs only when valid and ready are both high.
REQ-021 SHALL assert in_ready in IDLE and LOAD only; out_valid in OUT only.
REQ-022 In IDLE, an accepted byte SHALL be decoded as a command: 0x01 -> LOAD with base 0; 0x02 -> LOAD with base 16; 0x03 -> WAIT; any other value -> stay in IDLE and set err.
REQ-023 In LOAD, the k-th accepted byte (k = 0..N-1) SHALL produce a combinational write: mem_we=1, mem_addr=base+k, mem_wdata=in_data, in the same cycle as the transfer.
REQ-024 After the N-th operand byte, the FSM SHALL return to IDLE on the next edge; mem_we SHALL be 0 in every cycle without an accepted operand byte.
REQ-025 On entry to WAIT, dp_start SHALL be high for exactly the first WAIT cycle.
REQ-026 The controller SHALL register dp_result exactly DP_LAT cycles after the dp_start cycle, then go to OUT.
REQ-027 In OUT, the controller SHALL emit the captured result as 3 bytes, LSB first: [7:0], [15:8], [23:16].
REQ-028 While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-029 After the third byte is accepted, the FSM SHALL go to IDLE on the next edge.
REQ-030 Bytes offered on in_valid during WAIT or OUT SHALL NOT be consumed, because in_ready=0.
REQ-031 err SHALL clear only on reset; it SHALL NOT block subsequent commands.
REQ-032 Operand counter and byte counter SHALL be ceil(log2(N+1)) and 2 bits wide respectively, with no wrap beyond their terminal values.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately force: state IDLE, counters 0, captured result 0, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, dp_start=0, out_valid=0, out_data=0, busy=0, err=0.
REQ-034 Reset mid-LOAD SHALL abandon the load, leaving operand store contents unchanged; the first byte accepted after release SHALL be decoded as a command.
REQ-035 Reset mid-WAIT/OUT SHALL discard the result; no further dp_start or out_valid SHALL occur until a new 0x03 command.

Verification
REQ-036 Load: 0x02 then bytes 0x10..0x1F -> 16 mem_we pulses, addresses 16..31, the third carrying addr 18 and data 0x12; busy falls after the last byte.
REQ-037 End-to-end: A=all 0x01, B=1..16, model datapath (sum, DP_LAT=4), send 0x03 -> one dp_start pulse; out bytes 0x88, 0x00, 0x00; back in IDLE.
REQ-038 Backpressure: result 0x123456 with out_ready toggled 0,0,1,0,1,1 -> bytes 0x56, 0x34, 0x12 in order, each held while stalled.
REQ-039 Bad command 0x7F -> err=1, state IDLE, in_ready=1; a following 0x01 load proceeds normally with err still 1.
REQ-040 Reset after the 5th A byte -> all outputs at reset values; next byte 0x03 starts a run (dp_start seen), not an operand write.

Source files
------------

// File: rtl/dot_seq_ctrl.sv
// Byte-serial controller for a dot-product engine: loads A/B operands, fires the
// datapath, waits out its latency and streams the 3-byte result back LSB first.
`timescale 1ns/1ps
module dot_seq_ctrl #(
    parameter int N      = 16,
    parameter int DW     = 8,
    parameter int RW     = 24,
    parameter int DP_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          mem_we,
    output logic [5:0]    mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          dp_start,
    input  logic [RW-1:0] dp_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(N + 1);
    localparam int LW = $clog2(DP_LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] op_cnt;
    logic [1:0]    byte_cnt;
    logic [LW-1:0] lat_cnt;
    logic          base_b;
    logic [RW-1:0] result;
    logic          err_r;
    logic          in_fire;
    logic          out_fire;
    logic          op_last;
    logic          lat_done;
    logic          cmd_a;
    logic          cmd_b;
    logic          cmd_run;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign op_last  = (op_cnt == CW'(N - 1));
    assign lat_done = (lat_cnt == LW'(DP_LAT));
    assign cmd_a    = (in_data == DW'(1));
    assign cmd_b    = (in_data == DW'(2));
    assign cmd_run  = (in_data == DW'(3));
    assign busy     = (state != IDLE);
    assign err      = err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    if (cmd_a || cmd_b) begin
                        next_state = LOAD;
                    end else if (cmd_run) begin
                        next_state = WAIT;
                    end
                end
            end
            LOAD: if (in_fire && op_last) next_state = IDLE;
            WAIT: if (lat_done) next_state = OUT;
            OUT:  if (out_fire && (byte_cnt == 2'd2)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counters, operand base, captured result and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt   <= '0;
            byte_cnt <= '0;
            lat_cnt  <= '0;
            base_b   <= 1'b0;
            result   <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_cnt   <= '0;
                    byte_cnt <= '0;
                    lat_cnt  <= '0;
                    if (in_fire) begin
                        if (cmd_a) base_b <= 1'b0;
                        if (cmd_b) base_b <= 1'b1;
                        if (!(cmd_a || cmd_b || cmd_run)) err_r <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_fire) op_cnt <= op_last ? '0 : op_cnt + 1'b1;
                end
                WAIT: begin
                    if (lat_done) begin
                        result  <= dp_result;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_fire) byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand writes are combinational so they land in the same cycle as the transfer.
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        dp_start  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (state)
            IDLE: in_ready = 1'b1;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = (base_b ? 6'd16 : 6'd0) + 6'(op_cnt);
                    mem_wdata = in_data;
                end
            end
            WAIT: dp_start = (lat_cnt == '0);
            OUT: begin
                out_valid = 1'b1;
                case (byte_cnt)
                    2'd0:    out_data = result[DW-1:0];
                    2'd1:    out_data = result[2*DW-1:DW];
                    default: out_data = result[3*DW-1:2*DW];
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Self-checking bench for dot_seq_ctrl: table-driven end-to-end runs against a
// latency-exact datapath model, plus hand-written reset and backpressure sequences.
`timescale 1ns/1ps
module tb_dot_seq_ctrl;
    localparam int N      = 16;
    localparam int DW     = 8;
    localparam int RW     = 24;
    localparam int DP_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          mem_we;
    logic [5:0]    mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          dp_start;
    logic [RW-1:0] dp_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    dot_seq_ctrl #(.N(N), .DW(DW), .RW(RW), .DP_LAT(DP_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dp_start(dp_start), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    // Datapath model: the sum is only presented in the one cycle it is valid.
    logic [7:0]  mem [0:63];
    int          dp_lat_cnt;
    logic        force_en = 1'b0;
    logic [23:0] force_val = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_lat_cnt <= 0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (dp_start) dp_lat_cnt <= 1;
            else if (dp_lat_cnt != 0 && dp_lat_cnt <= DP_LAT) dp_lat_cnt <= dp_lat_cnt + 1;
            else dp_lat_cnt <= 0;
        end
    end

    always_comb begin
        int s;
        s = 0;
        dp_result = 24'hA5A5A5;
        if (dp_lat_cnt == DP_LAT) begin
            for (int i = 0; i < N; i++) s += int'(mem[i]) * int'(mem[16 + i]);
            dp_result = force_en ? force_val : s[23:0];
        end
    end

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  a_base;
        logic [7:0]  a_step;
        logic [7:0]  b_base;
        logic [7:0]  b_step;
        logic [23:0] exp;
    } vec_t;

    wr_t        wr_q[$];
    logic [7:0] out_q[$];
    int         checks = 0;
    int         passes = 0;
    int         dp_start_cnt = 0;
    int         out_valid_cnt = 0;
    logic       held_v = 1'b0;
    logic [7:0] held_d = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic failNow(input string name, input logic [31:0] act);
        checks++;
        $display("[TB] FAIL %s: got %0h expected none", name, act);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            wr_t w;
            logic [7:0] b;
            if (dp_start) dp_start_cnt++;
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    failNow("unexpected_write", {26'd0, mem_addr});
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("wr_addr", 32'(mem_addr), 32'(w.addr));
                    checkOutput("wr_data", 32'(mem_wdata), 32'(w.data));
                end
            end
            if (out_valid) begin
                out_valid_cnt++;
                if (held_v) checkOutput("out_hold", 32'(out_data), 32'(held_d));
                if (out_ready) begin
                    if (out_q.size() == 0) begin
                        failNow("unexpected_out", 32'(out_data));
                    end else begin
                        b = out_q.pop_front();
                        checkOutput("out_byte", 32'(out_data), 32'(b));
                    end
                end
                held_v = !out_ready;
                held_d = out_data;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!acc) failNow("host_byte_timeout", 32'(b));
    endtask

    task automatic loadVector(input logic [7:0] cmd, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b;
        logic [5:0] a;
        applyStimulus(cmd);
        checkOutput("busy_in_load", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            b = base + step * 8'(i);
            a = ((cmd == 8'h02) ? 6'd16 : 6'd0) + 6'(i);
            wr_q.push_back('{addr: a, data: b});
            applyStimulus(b);
        end
        checkOutput("busy_after_load", 32'(busy), 32'd0);
        checkOutput("writes_left", 32'(wr_q.size()), 32'd0);
    endtask

    task automatic runCompute(input logic [23:0] exp, input logic [5:0] stall_pat);
        int   s0;
        int   k;
        logic done;
        s0 = dp_start_cnt;
        k = 0;
        done = 1'b0;
        out_q.push_back(exp[7:0]);
        out_q.push_back(exp[15:8]);
        out_q.push_back(exp[23:16]);
        applyStimulus(8'h03);
        checkOutput("in_ready_wait", 32'(in_ready), 32'd0);
        for (int c = 0; c < 100; c++) begin
            if (!busy && k > 0) begin
                done = 1'b1;
                break;
            end
            out_ready = out_valid ? ((k < 6) ? stall_pat[k] : 1'b1) : 1'b0;
            if (out_valid) k++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        checkOutput("run_done", 32'(done), 32'd1);
        checkOutput("bytes_left", 32'(out_q.size()), 32'd0);
        checkOutput("dp_start_pulses", 32'(dp_start_cnt - s0), 32'd1);
        out_q.delete();
    endtask

    task automatic doReset();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_dp_start", 32'(dp_start), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        wr_q.delete();
        out_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[5];
        int   s0;
        int   v0;
        vecs[0] = '{8'h01, 8'h00, 8'h01, 8'h01, 24'h000088};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 24'h0FE010};
        vecs[2] = '{8'h00, 8'h01, 8'h00, 8'h01, 24'h0004D8};
        vecs[3] = '{8'h80, 8'h00, 8'h02, 8'h00, 24'h001000};
        vecs[4] = '{8'h10, 8'h10, 8'h03, 8'h00, 24'h001680};

        doReset();

        loadVector(8'h02, 8'h10, 8'h01);

        for (int v = 0; v < 5; v++) begin
            loadVector(8'h01, vecs[v].a_base, vecs[v].a_step);
            loadVector(8'h02, vecs[v].b_base, vecs[v].b_step);
            runCompute(vecs[v].exp, 6'h3F);
        end

        force_en  = 1'b1;
        force_val = 24'h123456;
        runCompute(24'h123456, 6'b110100);
        force_en  = 1'b0;

        applyStimulus(8'h7F);
        checkOutput("bad_cmd_err", 32'(err), 32'd1);
        checkOutput("bad_cmd_busy", 32'(busy), 32'd0);
        checkOutput("bad_cmd_in_ready", 32'(in_ready), 32'd1);
        loadVector(8'h01, 8'h05, 8'h01);
        checkOutput("err_sticky", 32'(err), 32'd1);

        applyStimulus(8'h01);
        for (int i = 0; i < 5; i++) begin
            wr_q.push_back('{addr: 6'(i), data: 8'(8'h40 + i)});
            applyStimulus(8'(8'h40 + i));
        end
        doReset();
        force_en  = 1'b1;
        force_val = 24'h00ABCD;
        runCompute(24'h00ABCD, 6'h3F);

        applyStimulus(8'h03);
        @(posedge clk);
        #1;
        doReset();
        s0 = dp_start_cnt;
        v0 = out_valid_cnt;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("no_start_after_rst", 32'(dp_start_cnt - s0), 32'd0);
        checkOutput("no_out_after_rst", 32'(out_valid_cnt - v0), 32'd0);
        checkOutput("idle_after_rst", 32'(busy), 32'd0);
        force_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
